// File: rtl/tex_cmd_defs_pkg.sv
// Shared definitions for the line-command receiver: character codes, state encodings,
// default line limit and small byte classifiers.
package tex_cmd_defs;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_9  = 8'h39;

  localparam int unsigned DEFAULT_MAX_LINE = 50;

  typedef enum logic [2:0] {
    StRxIdle,
    StRxStart,
    StRxData,
    StRxStop,
    StRxBreak
  } rx_state_e;

  typedef enum logic [1:0] {
    StPsIdle,
    StPsDig1,
    StPsDig2,
    StPsFlush
  } ps_state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_0) && (c <= CHAR_9);
  endfunction

  function automatic logic is_eol(input logic [7:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF);
  endfunction

endpackage

// File: rtl/tex_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, break (held-low) handling.
// strobe/data/frame_err are combinational in the stop-sample cycle.
module tex_uart_rx
  import tex_cmd_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       strobe,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF = CLKS_PER_BIT >> 1;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HalfCnt = CW'(HALF);
  localparam logic [CW-1:0] LastCnt = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxs;

  assign rxs = sync_q[1];

  // State registers; synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRxIdle;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Bit timing and framing.
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], rxd};
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    strobe    = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      StRxIdle: begin
        if (!rxs) begin
          state_d = StRxStart;
          cnt_d   = '0;
        end
      end
      StRxStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? StRxIdle : StRxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRxData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = StRxStop;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRxStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          strobe  = 1'b1;
          state_d = StRxIdle;
          if (!rxs) begin
            frame_err = 1'b1;
            // An all-zero byte with a low stop bit is a held-low line: wait it out.
            if (shift_q == 8'h00) state_d = StRxBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRxBreak: begin
        if (rxs) state_d = StRxIdle;
      end
      default: state_d = StRxIdle;
    endcase
  end

  assign data = shift_q;
  assign busy = (state_q != StRxIdle);

endmodule

// File: rtl/tex_line_cmd_rx.sv
// Decimal line-number command receiver: UART bytes -> parser -> registered line select.
// Optional echo of every framed byte is enabled with TEX_CMD_ECHO_EN.
module tex_line_cmd_rx
  import tex_cmd_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MAX_LINE     = DEFAULT_MAX_LINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [5:0] line,
  output logic       line_valid,
  output logic       err,
  output logic       busy
`ifdef TEX_CMD_ECHO_EN
  ,
  output logic [7:0] echo_data,
  output logic       echo_valid
`endif
);

  localparam logic [6:0] MaxLine = 7'(MAX_LINE);

  logic       rx_strobe, rx_frame_err, rx_busy;
  logic [7:0] rx_data;

  tex_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .strobe   (rx_strobe),
    .data     (rx_data),
    .frame_err(rx_frame_err),
    .busy     (rx_busy)
  );

  ps_state_e  ps_q, ps_d;
  logic [6:0] acc_q, acc_d;
  logic [5:0] line_q, line_d;
  logic       line_valid_q, line_valid_d;
  logic       err_q, err_d;
  logic [6:0] digit;
  logic [6:0] acc_x10;

  assign digit   = {3'b000, rx_data[3:0]};
  assign acc_x10 = (acc_q << 3) + (acc_q << 1);

  // Parser and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q         <= StPsIdle;
      acc_q        <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ps_q         <= ps_d;
      acc_q        <= acc_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      err_q        <= err_d;
    end
  end

  // Command parsing, one step per received byte.
  always_comb begin
    ps_d         = ps_q;
    acc_d        = acc_q;
    line_d       = line_q;
    line_valid_d = 1'b0;
    err_d        = 1'b0;
    if (rx_strobe) begin
      if (rx_frame_err) begin
        // Report once; a frame error while already flushing stays silent.
        err_d = (ps_q != StPsFlush);
        ps_d  = StPsFlush;
      end else begin
        unique case (ps_q)
          StPsIdle: begin
            if (is_digit(rx_data)) begin
              acc_d = digit;
              ps_d  = StPsDig1;
            end else if (!is_eol(rx_data)) begin
              err_d = 1'b1;
              ps_d  = StPsFlush;
            end
          end
          StPsDig1, StPsDig2: begin
            if (is_eol(rx_data)) begin
              ps_d = StPsIdle;
              if (acc_q <= MaxLine) begin
                line_d       = acc_q[5:0];
                line_valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else if ((ps_q == StPsDig1) && is_digit(rx_data)) begin
              acc_d = acc_x10 + digit;
              ps_d  = StPsDig2;
            end else begin
              err_d = 1'b1;
              ps_d  = StPsFlush;
            end
          end
          StPsFlush: begin
            if (is_eol(rx_data)) ps_d = StPsIdle;
          end
          default: ps_d = StPsIdle;
        endcase
      end
    end
  end

  assign line       = line_q;
  assign line_valid = line_valid_q;
  assign err        = err_q;
  assign busy       = rx_busy || (ps_q != StPsIdle);

`ifdef TEX_CMD_ECHO_EN
  logic [7:0] echo_data_q, echo_data_d;
  logic       echo_valid_q, echo_valid_d;

  // Echo every correctly framed byte alongside the parser update.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_data_q  <= '0;
      echo_valid_q <= 1'b0;
    end else begin
      echo_data_q  <= echo_data_d;
      echo_valid_q <= echo_valid_d;
    end
  end

  // Capture the byte on a clean stop bit.
  always_comb begin
    echo_data_d  = echo_data_q;
    echo_valid_d = 1'b0;
    if (rx_strobe && !rx_frame_err) begin
      echo_data_d  = rx_data;
      echo_valid_d = 1'b1;
    end
  end

  assign echo_data  = echo_data_q;
  assign echo_valid = echo_valid_q;
`endif

endmodule

// File: tb/tb_tex_line_cmd_rx.sv
// Bench for tex_line_cmd_rx: table-driven byte vectors, expected pulses queued as each byte
// is sent and matched by a monitor, plus hand-written break and mid-byte reset sequences.
module tb_tex_line_cmd_rx;

  localparam int unsigned CPB = 16;
  localparam int EV_NONE = -2;
  localparam int EV_ERR  = -1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [5:0] line;
  logic       line_valid;
  logic       err;
  logic       busy;
`ifdef TEX_CMD_ECHO_EN
  logic [7:0] echo_data;
  logic       echo_valid;
`endif

  tex_line_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .MAX_LINE    (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .line      (line),
    .line_valid(line_valid),
    .err       (err),
    .busy      (busy)
`ifdef TEX_CMD_ECHO_EN
    ,
    .echo_data (echo_data),
    .echo_valid(echo_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         seg;
    logic [7:0] ch;
    logic       stop;
    int         ev;
    int         gap;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add(input int seg, input logic [7:0] ch, input logic stop,
                              input int ev, input int gap);
    vec_t v;
    v.seg = seg; v.ch = ch; v.stop = stop; v.ev = ev; v.gap = gap;
    vecs.push_back(v);
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic run_seg(input int seg);
    foreach (vecs[i]) begin
      if (vecs[i].seg == seg) begin
        if (vecs[i].ev != EV_NONE) exp_q.push_back(vecs[i].ev);
        send_byte(vecs[i].ch, vecs[i].stop);
        tick(vecs[i].gap * CPB);
      end
    end
    tick(4);
  endtask

  task automatic end_seg(input string name, input int exp_line);
    check({name, "_line"}, int'(line), exp_line);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  // Every line_valid/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    int act;
    if (!rst && (line_valid || err)) begin
      act = (line_valid && err) ? 100 : (err ? EV_ERR : int'(line));
      if (exp_q.size() == 0) check("spurious_pulse", act, EV_NONE);
      else check("pulse", act, exp_q.pop_front());
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // seg 1: "7\r"
    add(1, "7", 1, EV_NONE, 0);  add(1, 8'h0D, 1, 7, 0);
    // seg 2: "42\n" then "\r\r"
    add(2, "4", 1, EV_NONE, 0);  add(2, "2", 1, EV_NONE, 0);  add(2, 8'h0A, 1, 42, 0);
    add(2, 8'h0D, 1, EV_NONE, 0); add(2, 8'h0D, 1, EV_NONE, 0);
    // seg 3: "51\r" out of range
    add(3, "5", 1, EV_NONE, 0);  add(3, "1", 1, EV_NONE, 0);  add(3, 8'h0D, 1, EV_ERR, 0);
    // seg 4: "4x\r5\r"
    add(4, "4", 1, EV_NONE, 0);  add(4, "x", 1, EV_ERR, 0);   add(4, 8'h0D, 1, EV_NONE, 0);
    add(4, "5", 1, EV_NONE, 0);  add(4, 8'h0D, 1, 5, 0);
    // seg 5: "123\r" third digit
    add(5, "1", 1, EV_NONE, 0);  add(5, "2", 1, EV_NONE, 0);  add(5, "3", 1, EV_ERR, 0);
    add(5, 8'h0D, 1, EV_NONE, 0);
    // seg 6: '3', bad-stop frame, "\r9\r"
    add(6, "3", 1, EV_NONE, 0);  add(6, "A", 0, EV_ERR, 2);   add(6, 8'h0D, 1, EV_NONE, 0);
    add(6, "9", 1, EV_NONE, 0);  add(6, 8'h0D, 1, 9, 0);
    // seg 7: after break, "\r8\r"
    add(7, 8'h0D, 1, EV_NONE, 0); add(7, "8", 1, EV_NONE, 0); add(7, 8'h0D, 1, 8, 0);
    // seg 8: after mid-byte reset, "1\r"
    add(8, "1", 1, EV_NONE, 0);  add(8, 8'h0D, 1, 1, 0);

    do_reset();
    check("rst_line", int'(line), 0);
    check("rst_line_valid", int'(line_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);

    run_seg(1);
    end_seg("seq7", 7);
    tick(3 * CPB);
    check("line_holds", int'(line), 7);

    do_reset();
    check("rst2_line", int'(line), 0);
    run_seg(2);
    end_seg("seq42", 42);
    run_seg(3);
    end_seg("seq51", 42);
    run_seg(4);
    end_seg("seq4x5", 5);
    run_seg(5);
    end_seg("seq123", 5);
    run_seg(6);
    end_seg("seqframe", 9);

    // Held-low line for 20 bit times: a single err pulse.
    exp_q.push_back(EV_ERR);
    rxd = 1'b0;
    tick(20 * CPB);
    check("break_busy", int'(busy), 1);
    rxd = 1'b1;
    tick(2 * CPB);
    run_seg(7);
    end_seg("seqbreak", 8);

    // Reset during data bit 3 of '9' (0x39: bits 1,0,0,1,...).
    rxd = 1'b0; tick(CPB);
    rxd = 1'b1; tick(CPB);
    rxd = 1'b0; tick(CPB);
    rxd = 1'b0; tick(CPB);
    rxd = 1'b1; tick(CPB / 2);
    check("midbyte_busy", int'(busy), 1);
    rst = 1'b1;
    tick(1);
    check("midrst_line", int'(line), 0);
    check("midrst_busy", int'(busy), 0);
    tick(1);
    rst = 1'b0;
    rxd = 1'b1;
    tick(CPB);
    check("postrst_line", int'(line), 0);
    run_seg(8);
    end_seg("seq1", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
